tx_sample_sched: RTL and testbench
==================================

Name: tx_sample_sched

Overview:
- Sequences the 4-ASK transmit datapath: accepts 2-bit symbols over a valid/ready handshake and maps them to 1s17 amplitude levels.
- Zero-stuffs each symbol to SAMPLES_PER_SYM samples and drives the TX pulse-shaping filter input once per sample period.
- After the last symbol, feeds FLUSH_SAMPLES zero samples so the TX/RCV filter cascade drains completely, then reports completion.

Parameters:
- CLKS_PER_SAMPLE, 4: clocks per output sample; must be >= 1.
- SAMPLES_PER_SYM, 4: upsampling factor, counting the symbol sample plus the zero samples; must be >= 1.
- FLUSH_SAMPLES, 22: number of trailing zero samples after the last symbol; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begins a burst when the block is IDLE.
- sym_in  in  2  symbol bits.
- sym_valid  in  1  sym_in is valid.
- sym_last  in  1  qualifies sym_in as the final symbol of the burst.
- sym_ready  out  1  the block accepts the symbol this cycle.
- x_out  out  18  signed 1s17 sample to the TX filter x_in.
- sample_en  out  1  one-cycle strobe marking a new x_out.
- sym_strobe  out  1  one-cycle strobe, coincident with sample_en, on symbol-bearing samples.
- busy  out  1  high in RUN or FLUSH.
- done  out  1  one-cycle pulse at end of flush.
- underrun  out  1  sticky flag: a symbol slot was missed.

Behaviour:
- Reset: state IDLE, all counters 0, x_out=0, sample_en=0, sym_strobe=0, sym_ready=0, busy=0, done=0, underrun=0. Reset mid-burst abandons the burst immediately with no done pulse.
- States are IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN when start=1.
  - On this transition, clock counter cc=0, phase counter ph=0, underrun cleared.
  - start is ignored in every other state.
- tick = (cc==CLKS_PER_SAMPLE-1) in RUN/FLUSH.
  - cc wraps to 0 on tick.
  - ph increments on tick and wraps at SAMPLES_PER_SYM-1.
- sym_ready = (state==RUN) && tick && (ph==0) && !last_seen. It is decoded from registers only, with no combinational path from sym_valid.
- On a RUN tick:
  - If ph==0 and sym_valid=1: accept the symbol; x_out <= LEVEL(sym_in); sym_strobe <= 1. If sym_last=1, set last_seen.
  - If ph==0 and sym_valid=0: x_out <= 0 and underrun <= 1. The slot is skipped, not retried, and ph still advances.
  - If ph!=0: x_out <= 0 (zero stuffing).
- sample_en <= tick, so x_out and sample_en update on the same edge.
  - Latency is one clock from the accepting edge to x_out/sample_en.
  - x_out holds its value between strobes.
- Symbol mapping uses Gray code: 00 -> -98304 (-0.75), 01 -> -32768 (-0.25), 11 -> +32768 (+0.25), 10 -> +98304 (+0.75).
- RUN -> FLUSH on the tick where last_seen=1 and ph==SAMPLES_PER_SYM-1. The last symbol's stuffing zeros are always emitted first.
- FLUSH:
  - Emits x_out=0 with sample_en on each tick.
  - A flush counter counts the ticks; after FLUSH_SAMPLES ticks the state goes to DONE.
- DONE: done=1 for one cycle, then IDLE; last_seen is cleared.
- busy=1 exactly in RUN/FLUSH.
- When CLKS_PER_SAMPLE=1, tick is high every cycle in RUN/FLUSH.
- When SAMPLES_PER_SYM=1, every tick is a symbol slot.

Optional Feature:
- Macro: TX_SCHED_PRBS_EN.
- Defined: a symbol slot with sym_valid=0 in RUN substitutes 2 bits from an internal PRBS-7 generator (x^7+x^6+1, seed 7'h7F, advanced 2 steps per substitution).
  - sym_strobe still asserts in that slot.
  - underrun is still set.
- Undefined: a symbol slot with sym_valid=0 emits a zero sample, and the generator is absent.

Decomposition:
- Package tx_sched_pkg holds:
  - typedef sample_t (logic signed [17:0]);
  - typedef sym_t (logic [1:0]);
  - the state enum sched_state_t;
  - constants LVL_P3=98304, LVL_P1=32768, LVL_M1=-32768, LVL_M3=-98304;
  - function map_sym(sym_t) -> sample_t.
- Sub-module tx_tick_gen: cc counter and tick output, with an enable and a synchronous clear.

Test Plan:
- Reset then start, with sym_valid held high and symbols 10,00,01,11 (last on 11), defaults:
  - sample_en every 4 clocks;
  - sym_ready high once per 16 clocks, first in the 4th cycle of RUN;
  - x_out sequence: 98304,0,0,0, -98304,0,0,0, -32768,0,0,0, 32768,0,0,0, then 22 zeros;
  - done pulses one cycle after the 22nd flush tick.
- sym_valid low for the second symbol slot: x_out=0 in that slot, underrun=1 and stays high, the following symbol goes to the next slot; the next start clears underrun.
- Reset asserted during FLUSH: the next cycle shows all outputs 0 and state IDLE, with no done pulse; a new start then runs normally.
- start pulsed while busy=1: no effect; the sample cadence and symbol order are unchanged.
- CLKS_PER_SAMPLE=1, SAMPLES_PER_SYM=1: sym_ready is high every RUN cycle, and 8 back-to-back symbols give 8 consecutive nonzero samples followed by 22 zeros.
- With TX_SCHED_PRBS_EN defined and sym_valid never asserted: the nonzero levels follow PRBS-7 pairs starting at seed 7F, and underrun=1.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// Shared types, levels and symbol mapping for the 4-ASK transmit scheduler.
// Levels are signed 1s17; the symbol map is Gray coded.
package tx_sched_pkg;

    typedef logic signed [17:0] sample_t;
    typedef logic [1:0]         sym_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } sched_state_t;

    localparam sample_t LVL_P3 = 18'sd98304;
    localparam sample_t LVL_P1 = 18'sd32768;
    localparam sample_t LVL_M1 = -18'sd32768;
    localparam sample_t LVL_M3 = -18'sd98304;

    function automatic sample_t map_sym(input sym_t s);
        sample_t v;
        unique case (s)
            2'b00:   v = LVL_M3;
            2'b01:   v = LVL_M1;
            2'b11:   v = LVL_P1;
            default: v = LVL_P3;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tx_tick_gen.sv
// Sample-period clock counter: tick marks the last clock of each sample period.
// Ports: clk, reset (sync, active-high), en, clr (sync clear), tick.
module tx_tick_gen
    import tx_sched_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CC_W =
        (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam logic [CC_W-1:0] CC_MAX = CC_W'(CLKS_PER_SAMPLE - 1);

    logic [CC_W-1:0] cc_q, cc_d;

    always_comb begin
        tick = en && (cc_q == CC_MAX);
        cc_d = cc_q;
        if (clr || !en) begin
            cc_d = '0;
        end else if (tick) begin
            cc_d = '0;
        end else begin
            cc_d = cc_q + CC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cc_q <= '0;
        end else begin
            cc_q <= cc_d;
        end
    end

endmodule

// File: rtl/tx_sample_sched.sv
// 4-ASK transmit sample scheduler: symbol handshake, zero stuffing, flush, done.
// Ports: clk, reset (sync, active-high), start, sym_in/sym_valid/sym_last,
//   sym_ready, x_out (1s17), sample_en, sym_strobe, busy, done, underrun.
// Build option: TX_SCHED_PRBS_EN fills empty symbol slots from a PRBS-7.
module tx_sample_sched
    import tx_sched_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 4,
    parameter int SAMPLES_PER_SYM = 4,
    parameter int FLUSH_SAMPLES   = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  sym_in,
    input  logic        sym_valid,
    input  logic        sym_last,
    output logic        sym_ready,
    output logic [17:0] x_out,
    output logic        sample_en,
    output logic        sym_strobe,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam int PH_W =
        (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
    localparam int FC_W =
        (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;
    localparam logic [PH_W-1:0] PH_MAX = PH_W'(SAMPLES_PER_SYM - 1);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FLUSH_SAMPLES - 1);

    sched_state_t    state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [FC_W-1:0] fc_q, fc_d;
    sample_t         x_q, x_d;
    logic            last_seen_q, last_seen_d;
    logic            sample_en_q, sample_en_d;
    logic            sym_strobe_q, sym_strobe_d;
    logic            underrun_q, underrun_d;
    logic            run, busy_w, go, tick;

    assign run    = (state_q == ST_RUN);
    assign busy_w = run || (state_q == ST_FLUSH);
    assign go     = (state_q == ST_IDLE) && start;

    tx_tick_gen #(
        .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (busy_w),
        .clr  (go),
        .tick (tick)
    );

    // Registered terms only: no path from sym_valid.
    assign sym_ready = run && tick && (ph_q == '0) && !last_seen_q;

`ifdef TX_SCHED_PRBS_EN
    logic [6:0] prbs_q, prbs_d;
    sym_t       prbs_sym;

    // Two steps of x^7+x^6+1 per substituted symbol.
    always_comb begin
        prbs_sym = {prbs_q[6] ^ prbs_q[5], prbs_q[5] ^ prbs_q[4]};
        prbs_d   = prbs_q;
        if (sym_ready && !sym_valid) begin
            prbs_d = {prbs_q[4:0], prbs_sym};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prbs_q <= 7'h7F;
        end else begin
            prbs_q <= prbs_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        fc_d         = fc_q;
        x_d          = x_q;
        last_seen_d  = last_seen_q;
        sample_en_d  = tick;
        sym_strobe_d = 1'b0;
        underrun_d   = underrun_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    ph_d       = '0;
                    fc_d       = '0;
                    underrun_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    x_d  = '0;
                    ph_d = (ph_q == PH_MAX) ? '0 : ph_q + PH_W'(1);
                    if (sym_ready) begin
                        if (sym_valid) begin
                            x_d          = map_sym(sym_in);
                            sym_strobe_d = 1'b1;
                            if (sym_last) begin
                                last_seen_d = 1'b1;
                            end
                        end else begin
                            underrun_d = 1'b1;
`ifdef TX_SCHED_PRBS_EN
                            x_d          = map_sym(prbs_sym);
                            sym_strobe_d = 1'b1;
`endif
                        end
                    end
                    // last_seen_d also covers a last symbol taken on
                    // this very tick (one sample per symbol).
                    if ((ph_q == PH_MAX) && last_seen_d) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (tick) begin
                    x_d  = '0;
                    fc_d = fc_q + FC_W'(1);
                    if (fc_q == FC_MAX) begin
                        fc_d    = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                last_seen_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ph_q         <= '0;
            fc_q         <= '0;
            x_q          <= '0;
            last_seen_q  <= 1'b0;
            sample_en_q  <= 1'b0;
            sym_strobe_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            fc_q         <= fc_d;
            x_q          <= x_d;
            last_seen_q  <= last_seen_d;
            sample_en_q  <= sample_en_d;
            sym_strobe_q <= sym_strobe_d;
            underrun_q   <= underrun_d;
        end
    end

    assign x_out      = x_q;
    assign sample_en  = sample_en_q;
    assign sym_strobe = sym_strobe_q;
    assign busy       = busy_w;
    assign done       = (state_q == ST_DONE);
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_tx_sample_sched.sv
// Bench for tx_sample_sched: default instance and a 1-clock, 1-sample instance.
// Expected samples come from a slot-level model of the burst.
module tb_tx_sample_sched;

    localparam int FLUSH = 22;

    logic clk = 1'b0;
    logic reset, start, sym_valid, sym_last, sel;
    logic [1:0] sym_in;

    logic r0, se0, ss0, b0, d0, u0;
    logic r1, se1, ss1, b1, d1, u1;
    logic [17:0] x0, x1;

    logic o_ready, o_se, o_ss, o_busy, o_done, o_ur;
    logic signed [17:0] o_x;

    int errors = 0;
    int checks = 0;

    bit         plan_v[$];
    logic [1:0] plan_s[$];

`ifdef TX_SCHED_PRBS_EN
    bit [6:0] pw[2];
`endif

    always #5 clk = ~clk;

    tx_sample_sched dut0 (
        .clk(clk), .reset(reset), .start(start & ~sel),
        .sym_in(sym_in), .sym_valid(sym_valid), .sym_last(sym_last),
        .sym_ready(r0), .x_out(x0), .sample_en(se0),
        .sym_strobe(ss0), .busy(b0), .done(d0), .underrun(u0)
    );

    tx_sample_sched #(
        .CLKS_PER_SAMPLE(1), .SAMPLES_PER_SYM(1), .FLUSH_SAMPLES(FLUSH)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start & sel),
        .sym_in(sym_in), .sym_valid(sym_valid), .sym_last(sym_last),
        .sym_ready(r1), .x_out(x1), .sample_en(se1),
        .sym_strobe(ss1), .busy(b1), .done(d1), .underrun(u1)
    );

    assign o_ready = sel ? r1 : r0;
    assign o_se    = sel ? se1 : se0;
    assign o_ss    = sel ? ss1 : ss0;
    assign o_busy  = sel ? b1 : b0;
    assign o_done  = sel ? d1 : d0;
    assign o_ur    = sel ? u1 : u0;
    assign o_x     = sel ? x1 : x0;

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Gray symbol -> amplitude index -> level in units of 0.25 (1s17).
    function automatic int level(input logic [1:0] g);
        int b;
        b = 2 * int'(g[1]) + int'(g[1] ^ g[0]);
        return (2 * b - 3) * 32768;
    endfunction

`ifdef TX_SCHED_PRBS_EN
    function automatic logic [1:0] prbs_next(input int k);
        logic [1:0] s;
        bit nb;
        s = '0;
        for (int i = 0; i < 2; i++) begin
            nb    = pw[k][6] ^ pw[k][5];
            pw[k] = {pw[k][5:0], nb};
            s     = {s[0], nb};
        end
        return s;
    endfunction
`endif

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, o_ready, 0);
        chk({tag, "_x"}, o_x, 0);
        chk({tag, "_se"}, o_se, 0);
        chk({tag, "_strobe"}, o_ss, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_underrun"}, o_ur, 0);
    endtask

    task automatic clear_inputs();
        start     = 1'b0;
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        sym_in    = 2'b00;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
`ifdef TX_SCHED_PRBS_EN
        pw[0] = 7'h7F;
        pw[1] = 7'h7F;
`endif
    endtask

    task automatic mk_plan(input int n, input int gap_pct);
        plan_v.delete();
        plan_s.delete();
        for (int i = 0; i < n; i++) begin
            plan_v.push_back((i == n - 1) ||
                             ($urandom_range(0, 99) >= gap_pct));
            plan_s.push_back(2'($urandom_range(0, 3)));
        end
    endtask

    // Runs one burst from plan_v/plan_s on the instance chosen by sel.
    task automatic burst(input string nm, input int abort_c,
                         input int start_c);
        int cps, sps, ns, tot, budget, slot, got_st, exp_st, nd;
        bit exp_ur, aborted;
        int exp_x[$], got_x[$], got_c[$], rdy_c[$], done_c[$];
        cps     = sel ? 1 : 4;
        sps     = sel ? 1 : 4;
        ns      = plan_v.size();
        exp_ur  = 1'b0;
        exp_st  = 0;
        got_st  = 0;
        aborted = 1'b0;
        for (int i = 0; i < ns; i++) begin
            if (plan_v[i]) begin
                exp_x.push_back(level(plan_s[i]));
                exp_st++;
            end else begin
                exp_ur = 1'b1;
`ifdef TX_SCHED_PRBS_EN
                exp_x.push_back(level(prbs_next(sel ? 1 : 0)));
                exp_st++;
`else
                exp_x.push_back(0);
`endif
            end
            for (int k = 1; k < sps; k++) exp_x.push_back(0);
        end
        for (int k = 0; k < FLUSH; k++) exp_x.push_back(0);
        tot    = exp_x.size();
        budget = tot * cps + 12;
        slot   = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start     = (c == start_c);
            sym_valid = (slot < ns) ? plan_v[slot] : 1'b0;
            sym_in    = (slot < ns) ? plan_s[slot] : 2'b00;
            sym_last  = (slot == ns - 1);
            if (c == 1) begin
                chk({nm, "_ur_cleared"}, o_ur, 0);
                chk({nm, "_busy_run"}, o_busy, 1);
            end
            if (o_se) begin
                got_x.push_back(int'(o_x));
                got_c.push_back(c);
            end
            if (o_ss) got_st++;
            if (o_ready) begin
                rdy_c.push_back(c);
                slot++;
            end
            if (o_done) begin
                done_c.push_back(c);
                chk({nm, "_busy_at_done"}, o_busy, 0);
            end
            if (c == abort_c) begin
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (done_c.size() > 0 && c >= done_c[0] + 3) break;
        end
        for (int j = 0; j < got_x.size() && j < tot; j++) begin
            chk($sformatf("%s_x%0d", nm, j), got_x[j], exp_x[j]);
            chk($sformatf("%s_xc%0d", nm, j), got_c[j], (j + 1) * cps + 1);
        end
        for (int i = 0; i < rdy_c.size() && i < ns; i++) begin
            chk($sformatf("%s_rdy%0d", nm, i), rdy_c[i], (i * sps + 1) * cps);
        end
        chk({nm, "_n_ready"}, rdy_c.size(), ns);
        if (aborted) begin
            @(negedge clk);
            clear_inputs();
            check_idle({nm, "_after_abort"});
            reset = 1'b0;
`ifdef TX_SCHED_PRBS_EN
            pw[0] = 7'h7F;
            pw[1] = 7'h7F;
`endif
            nd = done_c.size();
            repeat (40) begin
                @(negedge clk);
                if (o_done) nd++;
            end
            chk({nm, "_abort_no_done"}, nd, 0);
            chk({nm, "_abort_idle_busy"}, o_busy, 0);
            return;
        end
        chk({nm, "_n_samples"}, got_x.size(), tot);
        chk({nm, "_n_strobe"}, got_st, exp_st);
        chk({nm, "_n_done"}, done_c.size(), 1);
        chk({nm, "_done_cycle"},
            (done_c.size() > 0) ? done_c[0] : -1, tot * cps + 1);
        chk({nm, "_underrun"}, o_ur, exp_ur);
        chk({nm, "_busy_end"}, o_busy, 0);
    endtask

    initial begin
        sel = 1'b0;
        do_reset();
        @(negedge clk);
        check_idle("reset0");
        sel = 1'b1;
        check_idle("reset1");
        sel = 1'b0;

        plan_v = '{1, 1, 1, 1};
        plan_s = '{2'b10, 2'b00, 2'b01, 2'b11};
        burst("basic", -1, -1);

        mk_plan(5, 0);
        plan_v[1] = 1'b0;
        burst("gap", -1, -1);

        mk_plan(6, 0);
        burst("clean", -1, -1);

        mk_plan(5, 0);
        burst("start_busy", -1, 7);

        mk_plan(4, 0);
        burst("abort", 4 * 16 + 10, -1);

        mk_plan(5, 0);
        burst("after_abort", -1, 5 * 16 + 9);

        mk_plan(9, 30);
        burst("rand_gaps", -1, -1);

        sel = 1'b1;
        mk_plan(8, 0);
        burst("fast8", -1, -1);

        mk_plan(12, 25);
        burst("fast_gaps", -1, 3);

        sel = 1'b0;
        mk_plan(3, 0);
        burst("final", -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
